tx_mod_mapper: RTL and testbench
================================

TX_MOD_MAPPER -- requirements
Module: tx_mod_mapper

Interface
REQ-001 Parameter WORD_W, 16, input word width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter IQ_W, 8, signed I/Q output width; SHALL be at least 8.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  input word offered.
REQ-006 in_ready  out  1  mapper can accept a word this cycle.
REQ-007 in_data  in  WORD_W  payload word; bits are consumed MSB first.
REQ-008 in_mode  in  2  modulation select, sampled with the word: 0 BPSK, 1 QPSK, 2 16QAM, 3 reserved.
REQ-009 out_valid  out  1  symbol present on out_i and out_q.
REQ-010 out_ready  in  1  downstream accepts the symbol.
REQ-011 out_i, out_q  out  IQ_W each  signed constellation point.
REQ-012 out_last  out  1  high with the final symbol of a word.
REQ-013 err  out  1  one-cycle pulse when a reserved-mode word is accepted.

Function
REQ-014 Input handshake SHALL occur when in_valid and in_ready are both high on a clk edge. Output handshake SHALL occur when out_valid and out_ready are both high on a clk edge.
REQ-015 Bits per symbol SHALL be 1, 2 or 4 for BPSK, QPSK or 16QAM. A word SHALL produce WORD_W/bps symbols.
REQ-016 FSM states are IDLE and SEND.
- IDLE -> SEND on a valid-mode accept.
- SEND -> IDLE on the handshake of the out_last symbol unless a new word is accepted in the same cycle.
- SEND -> SEND when a new word is accepted in that same cycle.
REQ-017 in_ready SHALL equal (state==IDLE) OR (out_valid AND out_ready AND out_last). This gives zero-bubble back-to-back words.
REQ-018 Latency: after a word is accepted on edge N, its first symbol SHALL be valid after edge N. No combinational path SHALL exist from in_* to out_*.
REQ-019 While out_valid is high and out_ready is low, out_i, out_q and out_last SHALL hold stable.
REQ-020 Symbol bits SHALL be taken MSB first; b0 is the earliest bit.
REQ-021 BPSK mapping: I = +A_B for b0=0 and -A_B for b0=1; Q = 0.
REQ-022 QPSK mapping: I from b0 and Q from b1; 0 maps to +A_Q and 1 maps to -A_Q.
REQ-023 16QAM mapping: I from b0b1 and Q from b2b3, Gray-coded; 00=+3U, 01=+1U, 11=-1U, 10=-3U.
REQ-024 Amplitudes for IQ_W=8: A_B=90, A_Q=64, U=30. For larger IQ_W, each SHALL be left-shifted by IQ_W-8.
REQ-025 A mode-3 word SHALL be accepted and discarded, pulse err for exactly one cycle, and produce no symbols. State is unchanged.
REQ-026 in_mode SHALL be latched per word; changing it mid-word SHALL have no effect on the word in flight.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously enter IDLE.
- Outputs: out_valid=0, out_i=0, out_q=0, out_last=0, err=0.
- Clear the symbol counter and shift register.
- in_ready SHALL be 1 after rst_n deasserts.
REQ-028 Reset mid-word SHALL discard the remaining symbols. The first word after reset SHALL map from its MSB.

Structure
REQ-029 A shared package tx_pkg SHALL hold the mode enum, bits-per-symbol constants and the amplitude constants A_B, A_Q and U.
REQ-030 Constellation lookup SHALL live in a combinational sub-module tx_sym_map (mode and 4 bits in; I and Q out). Its result SHALL be registered in tx_mod_mapper.

Verification
REQ-031 QPSK 0xABCD with out_ready=1 -> 8 symbols (I,Q): (-64,+64)x3, (-64,-64), (-64,-64), (+64,+64), (-64,-64), (+64,-64); out_last on the 8th.
REQ-032 BPSK 0x8001 -> 16 symbols: -90, then fourteen +90, then -90; Q=0 throughout; out_last on the 16th.
REQ-033 16QAM 0x1E4B -> (+90,+30), (-30,-90), (+30,+90), (-90,-30); out_last on the 4th.
REQ-034 QPSK 0xABCD with out_ready low for 5 cycles at symbol 3 -> symbol 3 held, in_ready=0; the sequence then resumes unchanged.
REQ-035 Two QPSK words with in_valid held high and out_ready=1 -> 16 consecutive out_valid cycles with no gap; the second accept coincides with the first out_last handshake.
REQ-036 Reserved-mode word -> err high for 1 cycle, no out_valid. Separately, rst_n low at symbol 4 of a QPSK word -> out_valid drops immediately, then a fresh word maps correctly.

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: shared types and constants for the TX modulation mapper.
// Holds mode/state enums, bits-per-symbol values and base amplitudes.
package tx_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_RSV   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int BPS_BPSK  = 1;
  localparam int BPS_QPSK  = 2;
  localparam int BPS_QAM16 = 4;

  // Base amplitudes for an 8-bit I/Q path.
  localparam int A_B = 90;
  localparam int A_Q = 64;
  localparam int U   = 30;

  function automatic int bps(mode_e m);
    int r;
    r = 0;
    unique case (m)
      MODE_BPSK:  r = BPS_BPSK;
      MODE_QPSK:  r = BPS_QPSK;
      MODE_QAM16: r = BPS_QAM16;
      MODE_RSV:   r = 0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tx_mod_mapper_if.sv
// tx_mod_mapper_if: word-in / symbol-out handshake bundle.
// master drives words and out_ready; slave is the mapper.
interface tx_mod_mapper_if #(
  parameter int WORD_W = 16,
  parameter int IQ_W   = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_W-1:0]      in_data;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [IQ_W-1:0] out_i;
  logic signed [IQ_W-1:0] out_q;
  logic                   out_last;
  logic                   err;

  modport master (
    output in_valid, in_data, in_mode,
    output out_ready,
    input  in_ready, out_valid,
    input  out_i, out_q, out_last, err
  );

  modport slave (
    input  in_valid, in_data, in_mode,
    input  out_ready,
    output in_ready, out_valid,
    output out_i, out_q, out_last, err
  );

endinterface

// File: rtl/tx_sym_map.sv
// tx_sym_map: combinational constellation lookup.
// i_mode, i_bits (bit 3 = earliest bit) in; o_i, o_q out.
module tx_sym_map
  import tx_pkg::*;
#(
  parameter int IQ_W = 8
) (
  input  mode_e                  i_mode,
  input  logic [3:0]             i_bits,
  output logic signed [IQ_W-1:0] o_i,
  output logic signed [IQ_W-1:0] o_q
);

  localparam int SH = IQ_W - 8;

  localparam logic signed [IQ_W-1:0] P_AB =
    IQ_W'(A_B << SH);
  localparam logic signed [IQ_W-1:0] P_AQ =
    IQ_W'(A_Q << SH);
  localparam logic signed [IQ_W-1:0] P_U1 =
    IQ_W'(U << SH);
  localparam logic signed [IQ_W-1:0] P_U3 =
    IQ_W'((3 * U) << SH);

  // Gray-coded 4-PAM level.
  function automatic logic signed [IQ_W-1:0]
    pam4(input logic [1:0] b);
    logic signed [IQ_W-1:0] r;
    r = '0;
    unique case (b)
      2'b00: r = P_U3;
      2'b01: r = P_U1;
      2'b11: r = -P_U1;
      2'b10: r = -P_U3;
    endcase
    return r;
  endfunction

  always_comb begin
    o_i = '0;
    o_q = '0;
    unique case (i_mode)
      MODE_BPSK: begin
        o_i = i_bits[3] ? -P_AB : P_AB;
      end
      MODE_QPSK: begin
        o_i = i_bits[3] ? -P_AQ : P_AQ;
        o_q = i_bits[2] ? -P_AQ : P_AQ;
      end
      MODE_QAM16: begin
        o_i = pam4(i_bits[3:2]);
        o_q = pam4(i_bits[1:0]);
      end
      MODE_RSV: begin
        o_i = '0;
        o_q = '0;
      end
    endcase
  end

endmodule

// File: rtl/tx_mod_mapper.sv
// tx_mod_mapper: splits words MSB-first into BPSK/QPSK/16QAM symbols.
// clk, rst_n (async low); bus: slave side of tx_mod_mapper_if.
module tx_mod_mapper
  import tx_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int IQ_W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  tx_mod_mapper_if.slave bus
);

  localparam int CW = $clog2(WORD_W + 1);

  function automatic logic [CW-1:0] nsym(mode_e m);
    int b;
    b = bps(m);
    return (b == 0) ? '0 : CW'(WORD_W / b);
  endfunction

  state_e                 r_state;
  mode_e                  r_mode;
  logic [WORD_W-1:0]      r_shift;
  logic [CW-1:0]          r_left;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_err;
  logic signed [IQ_W-1:0] r_i;
  logic signed [IQ_W-1:0] r_q;

  logic                   w_in_ready;
  logic                   w_out_hs;
  logic                   w_acc;
  logic                   w_rsv;
  logic                   w_load;
  mode_e                  w_in_mode;
  mode_e                  w_map_mode;
  logic [3:0]             w_map_bits;
  logic signed [IQ_W-1:0] w_i;
  logic signed [IQ_W-1:0] w_q;

  assign w_out_hs   = r_valid & bus.out_ready;
  // A new word may enter on the same edge the last symbol leaves.
  assign w_in_ready = (r_state == ST_IDLE)
                    | (w_out_hs & r_last);
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_in_mode  = mode_e'(bus.in_mode);
  assign w_rsv      = (w_in_mode == MODE_RSV);
  assign w_load     = w_acc & ~w_rsv;

  // One lookup serves both a fresh word and the next stored symbol.
  assign w_map_mode = w_load ? w_in_mode : r_mode;
  assign w_map_bits = w_load ? bus.in_data[WORD_W-1 -: 4]
                             : r_shift[WORD_W-1 -: 4];

  tx_sym_map #(
    .IQ_W (IQ_W)
  ) u_map (
    .i_mode (w_map_mode),
    .i_bits (w_map_bits),
    .o_i    (w_i),
    .o_q    (w_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_BPSK;
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_i     <= '0;
      r_q     <= '0;
    end else begin
      r_err <= w_acc & w_rsv;
      if (w_load) begin
        r_state <= ST_SEND;
        r_valid <= 1'b1;
        r_mode  <= w_in_mode;
        r_i     <= w_i;
        r_q     <= w_q;
        r_shift <= bus.in_data << bps(w_in_mode);
        r_left  <= nsym(w_in_mode) - CW'(1);
        r_last  <= (nsym(w_in_mode) == CW'(1));
      end else if (w_out_hs) begin
        if (r_last) begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_i     <= '0;
          r_q     <= '0;
        end else begin
          r_i     <= w_i;
          r_q     <= w_q;
          r_shift <= r_shift << bps(r_mode);
          r_left  <= r_left - CW'(1);
          r_last  <= (r_left == CW'(1));
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_i     = r_i;
  assign bus.out_q     = r_q;
  assign bus.out_last  = r_last;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_tx_mod_mapper.sv
// tb_tx_mod_mapper: scoreboard bench for tx_mod_mapper.
// Driver pushes modelled symbols on accept; monitor pops on output handshake.
module tb_tx_mod_mapper;
  import tx_pkg::*;

  localparam int WORD_W = 16;
  localparam int IQ_W   = 8;
  localparam int SCALE  = 1 << (IQ_W - 8);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  tx_mod_mapper_if #(.WORD_W(WORD_W), .IQ_W(IQ_W)) bus ();

  tx_mod_mapper #(.WORD_W(WORD_W), .IQ_W(IQ_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int i;
    int q;
    bit last;
  } sym_t;

  sym_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int err_pend = 0;
  int hs_count = 0;
  int run = 0;
  int max_run = 0;
  int bp_pct = 0;
  int stall_left = 0;
  int stall_trig = -1;
  bit acc_last = 0;

  task automatic chk(string nm, logic signed [63:0] got,
                     logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference model: symbols straight from the mapping rules.
  function automatic int gray_lvl(int g);
    int bin;
    bin = ((g >> 1) * 2) + (((g >> 1) ^ g) & 1);
    return (3 - 2 * bin) * U * SCALE;
  endfunction

  task automatic model_word(logic [WORD_W-1:0] d, int m);
    int nb, n, v;
    sym_t s;
    if (m == 3) begin
      err_pend++;
      return;
    end
    nb = 1 << m;
    n  = WORD_W / nb;
    for (int k = 0; k < n; k++) begin
      v = int'(d >> (WORD_W - (k + 1) * nb)) & ((1 << nb) - 1);
      s.last = (k == n - 1);
      if (nb == 1) begin
        s.i = v ? -A_B * SCALE : A_B * SCALE;
        s.q = 0;
      end else if (nb == 2) begin
        s.i = (v >> 1) ? -A_Q * SCALE : A_Q * SCALE;
        s.q = (v & 1) ? -A_Q * SCALE : A_Q * SCALE;
      end else begin
        s.i = gray_lvl(v >> 2);
        s.q = gray_lvl(v & 3);
      end
      exp_q.push_back(s);
    end
  endtask

  // out_ready: random backpressure, or a forced stall at a given symbol.
  always @(negedge clk) begin
    if (stall_trig >= 0 && bus.out_valid &&
        hs_count == stall_trig) begin
      stall_left = 5;
      stall_trig = -1;
    end
    if (stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
    end else begin
      bus.out_ready = ($urandom_range(99) >= bp_pct);
    end
  end

  logic signed [IQ_W-1:0] h_i, h_q;
  logic h_last;
  bit   h_hold = 0;

  always @(negedge clk) begin
    sym_t e;
    #2;
    if (!rst_n) begin
      h_hold = 0;
      run = 0;
    end else begin
      if (h_hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_i", bus.out_i, h_i);
        chk("hold_q", bus.out_q, h_q);
        chk("hold_last", bus.out_last, h_last);
      end
      if (bus.err) begin
        checks++;
        if (err_pend == 0) begin
          errors++;
          $display("FAIL err_pulse got 1 expected 0");
        end else begin
          err_pend--;
        end
      end
      if (bus.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_symbol got %0d,%0d expected none",
                   bus.out_i, bus.out_q);
        end else begin
          e = exp_q.pop_front();
          chk("sym_i", bus.out_i, e.i);
          chk("sym_q", bus.out_q, e.q);
          chk("sym_last", bus.out_last, e.last);
        end
        hs_count++;
        h_hold = 0;
      end else if (bus.out_valid) begin
        h_hold = 1;
        h_i    = bus.out_i;
        h_q    = bus.out_q;
        h_last = bus.out_last;
        chk("stall_in_ready", bus.in_ready, 0);
      end else begin
        h_hold = 0;
      end
    end
  end

  task automatic send_word(logic [WORD_W-1:0] d,
                           logic [1:0] m);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    while (!ok && n < 300) begin
      #1;
      if (bus.in_ready) begin
        model_word(d, int'(m));
        acc_last = bus.out_valid && bus.out_ready &&
                   bus.out_last;
        ok = 1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 expected 1");
      return;
    end
    @(posedge clk);
    #1;
    if (m == 2'd3) begin
      chk("rsv_err", bus.err, 1);
      chk("rsv_no_valid", bus.out_valid, 0);
    end else begin
      chk("first_latency", bus.out_valid, 1);
    end
  endtask

  task automatic idle(int cyc);
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = WORD_W'($urandom);
      bus.in_mode  = 2'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) &&
           n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_timeout", (n >= 3000), 0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int base, n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_i", bus.out_i, 0);
    chk("rst_q", bus.out_q, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rst_in_ready", bus.in_ready, 1);

    // Directed words, no backpressure.
    bp_pct = 0;
    send_word(16'hABCD, 2'd1);
    idle(1);
    drain();
    send_word(16'h8001, 2'd0);
    idle(1);
    drain();
    send_word(16'h1E4B, 2'd2);
    idle(1);
    drain();

    // Stall at the third symbol.
    stall_trig = hs_count + 2;
    send_word(16'hABCD, 2'd1);
    idle(1);
    drain();

    // Back-to-back words with in_valid held.
    max_run = 0;
    send_word(16'hABCD, 2'd1);
    send_word(16'h5A3C, 2'd1);
    chk("b2b_acc_on_last", acc_last, 1);
    idle(1);
    drain();
    chk("b2b_run", max_run, 16);

    // Reserved mode.
    send_word(16'h1234, 2'd3);
    idle(3);
    drain();
    chk("rsv_err_done", err_pend, 0);

    // Reset in the middle of a word.
    base = hs_count;
    send_word(16'hABCD, 2'd1);
    idle(1);
    n = 0;
    while (hs_count != base + 3 && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("mid_rst_reach", (n < 100), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_i", bus.out_i, 0);
    chk("mid_rst_last", bus.out_last, 0);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1 chk("mid_rst_in_ready", bus.in_ready, 1);
    send_word(16'h1E4B, 2'd2);
    idle(1);
    drain();

    // Random traffic with backpressure.
    bp_pct = 30;
    for (int w = 0; w < 150; w++) begin
      send_word(WORD_W'($urandom), 2'($urandom_range(3)));
      if ($urandom_range(2) == 0)
        idle($urandom_range(1, 3));
    end
    idle(1);
    drain();
    idle(3);
    chk("final_err_pend", err_pend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
